// File: rtl/decode_stage_reg.sv
// Registered decode stage for the 9-bit accumulator ISA: ID/EX control register with
// stall/flush/bubble handling, halt drain sequencing, saturating count and sticky illegal flag.
module decode_stage_reg #(
    parameter int INSTR_W    = 9,
    parameter int OPC_W      = 5,
    parameter int RADDR_W    = 5,
    parameter int CNT_W      = 32,
    parameter int HALT_DRAIN = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               valid_in,
    input  logic               stall,
    input  logic               flush,
    output logic               valid_out,
    output logic [RADDR_W-1:0] rd0,
    output logic [RADDR_W-1:0] rd1,
    output logic [RADDR_W-1:0] wr_reg,
    output logic               wr_en,
    output logic [3:0]         alu_op,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [1:0]         reg_to_mem,
    output logic               move,
    output logic               imm,
    output logic [1:0]         quarter,
    output logic               branch,
    output logic               jump,
    output logic               halting,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_count
);

    typedef struct packed {
        logic               valid;
        logic [RADDR_W-1:0] rd0;
        logic [RADDR_W-1:0] rd1;
        logic [RADDR_W-1:0] wr_reg;
        logic               wr_en;
        logic [3:0]         alu_op;
        logic               mem_rd;
        logic               mem_wr;
        logic [1:0]         reg_to_mem;
        logic               move;
        logic               imm;
        logic [1:0]         quarter;
        logic               branch;
        logic               jump;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{wr_reg: {RADDR_W{1'b1}}, default: '0};

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    localparam logic [3:0] DRAIN_INIT = 4'(HALT_DRAIN - 1);

    localparam logic [RADDR_W-1:0] R_ADR  = RADDR_W'(4);
    localparam logic [RADDR_W-1:0] R_MATH = RADDR_W'(5);
    localparam logic [RADDR_W-1:0] R_CNT  = RADDR_W'(7);

    ctrl_t            ctrl_q, ctrl_d, dec;
    logic [1:0]       state_q, state_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d;
    logic             legal, is_halt, advance;
    logic [OPC_W-1:0] opcode;
    logic [RADDR_W-1:0] fa, fb;
    int unsigned      op;

    assign opcode = instr_in[INSTR_W-1 -: OPC_W];
    assign fa     = {{(RADDR_W-2){1'b0}}, instr_in[3:2]};
    assign fb     = {{(RADDR_W-2){1'b0}}, instr_in[1:0]};

    always_comb begin
        op        = 32'(opcode);
        dec       = BUBBLE;
        dec.valid = 1'b1;
        legal     = 1'b1;
        is_halt   = 1'b0;
        case (op)
            0, 1: begin
                dec.rd0 = fa; dec.rd1 = R_MATH; dec.wr_reg = fb; dec.wr_en = 1'b1;
                dec.alu_op = 4'(op);
            end
            2: begin
                dec.move = 1'b1; dec.rd0 = fa; dec.wr_reg = fb; dec.wr_en = 1'b1;
            end
            3, 4, 5: begin
                dec.move = 1'b1; dec.rd0 = fb; dec.wr_en = 1'b1;
                dec.wr_reg = (op == 3) ? R_ADR : (op == 4) ? R_MATH : R_CNT;
            end
            6: begin
                dec.imm = 1'b1; dec.wr_reg = R_ADR; dec.wr_en = 1'b1;
            end
            7, 8, 9: begin
                dec.move = 1'b1; dec.wr_reg = fb; dec.wr_en = 1'b1;
                dec.rd0 = (op == 7) ? R_ADR : (op == 8) ? R_MATH : R_CNT;
            end
            10, 11, 12, 13: begin
                dec.move = 1'b1; dec.rd0 = fa; dec.wr_reg = fb; dec.wr_en = 1'b1;
                dec.quarter = 2'(op - 32'd10);
            end
            14: begin
                dec.imm = 1'b1; dec.wr_reg = R_MATH; dec.wr_en = 1'b1;
            end
            15, 16, 17, 18, 19: begin
                dec.branch = 1'b1; dec.rd0 = fa; dec.rd1 = fb;
                case (op)
                    15:      dec.alu_op = 4'd7;
                    16:      dec.alu_op = 4'd8;
                    17:      dec.alu_op = 4'd6;
                    18:      dec.alu_op = 4'd5;
                    default: dec.alu_op = 4'd4;
                endcase
            end
            20, 21: begin
                dec.rd0 = fa; dec.wr_reg = fb; dec.wr_en = 1'b1;
                dec.alu_op = (op == 20) ? 4'd2 : 4'd3;
            end
            22: begin
                dec.mem_rd = 1'b1; dec.rd1 = R_ADR; dec.wr_reg = fb; dec.wr_en = 1'b1;
            end
            23: begin
                dec.mem_wr = 1'b1; dec.rd1 = R_ADR; dec.reg_to_mem = instr_in[1:0];
            end
            24: begin
                dec.branch = 1'b1; dec.jump = 1'b1; dec.alu_op = 4'd7;
            end
            25: begin
                dec.imm = 1'b1; dec.wr_reg = fb; dec.wr_en = 1'b1;
            end
            26:      is_halt = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // A flush still counts as a drain step; only a plain stall freezes the stage.
    assign advance = flush || !stall;

    always_comb begin
        ctrl_d  = ctrl_q;
        state_d = state_q;
        dcnt_d  = dcnt_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        if (advance) begin
            ctrl_d = BUBBLE;
            if (state_q == S_DRAIN) begin
                if (dcnt_q == 4'd0) state_d = S_HALTED;
                else                dcnt_d  = dcnt_q - 4'd1;
            end else if (state_q == S_RUN && valid_in && !flush) begin
                if (!legal) begin
                    ill_d = 1'b1;
                end else begin
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                    if (is_halt) begin
                        state_d = S_DRAIN;
                        dcnt_d  = DRAIN_INIT;
                    end else begin
                        ctrl_d = dec;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= BUBBLE;
            state_q <= S_RUN;
            dcnt_q  <= 4'd0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    assign valid_out   = ctrl_q.valid;
    assign rd0         = ctrl_q.rd0;
    assign rd1         = ctrl_q.rd1;
    assign wr_reg      = ctrl_q.wr_reg;
    assign wr_en       = ctrl_q.wr_en;
    assign alu_op      = ctrl_q.alu_op;
    assign mem_rd      = ctrl_q.mem_rd;
    assign mem_wr      = ctrl_q.mem_wr;
    assign reg_to_mem  = ctrl_q.reg_to_mem;
    assign move        = ctrl_q.move;
    assign imm         = ctrl_q.imm;
    assign quarter     = ctrl_q.quarter;
    assign branch      = ctrl_q.branch;
    assign jump        = ctrl_q.jump;
    assign halting     = (state_q == S_DRAIN);
    assign halted      = (state_q == S_HALTED);
    assign illegal     = ill_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_decode_stage_reg.sv
// Directed bench for decode_stage_reg: an ISA-level reference model checked every cycle,
// plus literal spot checks; a second instance with a 4-bit counter covers saturation.
module tb_decode_stage_reg;

    logic       clk, reset, valid_in, stall, flush;
    logic [8:0] instr_in;

    logic       valid_out, wr_en, mem_rd, mem_wr, move, imm, branch, jump;
    logic       halting, halted, illegal;
    logic [4:0] rd0, rd1, wr_reg;
    logic [3:0] alu_op;
    logic [1:0] reg_to_mem, quarter;
    logic [31:0] instr_count;

    logic       b_valid_out, b_wr_en, b_mem_rd, b_mem_wr, b_move, b_imm, b_branch, b_jump;
    logic       b_halting, b_halted, b_illegal;
    logic [4:0] b_rd0, b_rd1, b_wr_reg;
    logic [3:0] b_alu_op;
    logic [1:0] b_reg_to_mem, b_quarter;
    logic [3:0] b_instr_count;

    decode_stage_reg u_dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .valid_in(valid_in),
        .stall(stall), .flush(flush), .valid_out(valid_out), .rd0(rd0), .rd1(rd1),
        .wr_reg(wr_reg), .wr_en(wr_en), .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .reg_to_mem(reg_to_mem), .move(move), .imm(imm), .quarter(quarter),
        .branch(branch), .jump(jump), .halting(halting), .halted(halted),
        .illegal(illegal), .instr_count(instr_count)
    );

    decode_stage_reg #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .instr_in(instr_in), .valid_in(valid_in),
        .stall(stall), .flush(flush), .valid_out(b_valid_out), .rd0(b_rd0), .rd1(b_rd1),
        .wr_reg(b_wr_reg), .wr_en(b_wr_en), .alu_op(b_alu_op), .mem_rd(b_mem_rd),
        .mem_wr(b_mem_wr), .reg_to_mem(b_reg_to_mem), .move(b_move), .imm(b_imm),
        .quarter(b_quarter), .branch(b_branch), .jump(b_jump), .halting(b_halting),
        .halted(b_halted), .illegal(b_illegal), .instr_count(b_instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd0, rd1, wr;
        logic       wr_en;
        logic [3:0] alu;
        logic       mem_rd, mem_wr;
        logic [1:0] r2m;
        logic       move, imm;
        logic [1:0] quarter;
        logic       branch, jump;
        logic       halting, halted, illegal;
    } obs_t;

    int n_vec = 0, n_mis = 0;
    bit check_en = 0;

    // Reference state
    obs_t   m;
    longint m_cnt;
    int     m_cnt4;
    int     m_mode;   // 0 run, 1 drain, 2 halted
    int     m_rem;    // edges left until halted

    function automatic obs_t bubble_f();
        obs_t b = '0;
        b.wr = 5'd31;
        return b;
    endfunction

    // ISA sheet: fields for legal non-halt opcodes.
    function automatic obs_t isa(int op, logic [3:0] lo);
        obs_t f = bubble_f();
        logic [4:0] a = {3'b0, lo[3:2]};
        logic [4:0] b = {3'b0, lo[1:0]};
        int br_alu[5] = '{7, 8, 6, 5, 4};
        int sp[3] = '{4, 5, 7};
        f.valid = 1;
        if (op <= 1)       begin f.rd0 = a; f.rd1 = 5; f.wr = b; f.wr_en = 1; f.alu = 4'(op); end
        else if (op == 2)  begin f.move = 1; f.rd0 = a; f.wr = b; f.wr_en = 1; end
        else if (op <= 5)  begin f.move = 1; f.rd0 = b; f.wr = 5'(sp[op-3]); f.wr_en = 1; end
        else if (op == 6)  begin f.imm = 1; f.wr = 4; f.wr_en = 1; end
        else if (op <= 9)  begin f.move = 1; f.rd0 = 5'(sp[op-7]); f.wr = b; f.wr_en = 1; end
        else if (op <= 13) begin f.move = 1; f.rd0 = a; f.wr = b; f.wr_en = 1; f.quarter = 2'(op-10); end
        else if (op == 14) begin f.imm = 1; f.wr = 5; f.wr_en = 1; end
        else if (op <= 19) begin f.branch = 1; f.rd0 = a; f.rd1 = b; f.alu = 4'(br_alu[op-15]); end
        else if (op <= 21) begin f.rd0 = a; f.wr = b; f.wr_en = 1; f.alu = 4'(op-18); end
        else if (op == 22) begin f.mem_rd = 1; f.rd1 = 4; f.wr = b; f.wr_en = 1; end
        else if (op == 23) begin f.mem_wr = 1; f.rd1 = 4; f.r2m = lo[1:0]; end
        else if (op == 24) begin f.branch = 1; f.jump = 1; f.alu = 7; end
        else               begin f.imm = 1; f.wr = b; f.wr_en = 1; end
        return f;
    endfunction

    function automatic void set_fields(obs_t f);
        m.valid = f.valid; m.rd0 = f.rd0; m.rd1 = f.rd1; m.wr = f.wr; m.wr_en = f.wr_en;
        m.alu = f.alu; m.mem_rd = f.mem_rd; m.mem_wr = f.mem_wr; m.r2m = f.r2m;
        m.move = f.move; m.imm = f.imm; m.quarter = f.quarter; m.branch = f.branch;
        m.jump = f.jump;
    endfunction

    always @(posedge clk) begin : model
        int op;
        op = int'(instr_in[8:4]);
        if (reset) begin
            m = bubble_f(); m_cnt = 0; m_cnt4 = 0; m_mode = 0; m_rem = 0;
        end else if (flush || !stall) begin
            if (!flush && m_mode == 0 && valid_in) begin
                set_fields(bubble_f());
                if (op >= 27) m.illegal = 1;
                else begin
                    if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                    if (m_cnt4 < 15) m_cnt4++;
                    if (op == 26) begin m_mode = 1; m_rem = 3; end
                    else set_fields(isa(op, instr_in[3:0]));
                end
            end else begin
                set_fields(bubble_f());
                if (m_mode == 1) begin
                    m_rem--;
                    if (m_rem == 0) m_mode = 2;
                end
            end
        end
        m.halting = (m_mode == 1);
        m.halted  = (m_mode == 2);
    end

    always @(negedge clk) begin : compare
        obs_t act;
        if (check_en) begin
            act = {valid_out, rd0, rd1, wr_reg, wr_en, alu_op, mem_rd, mem_wr, reg_to_mem,
                   move, imm, quarter, branch, jump, halting, halted, illegal};
            n_vec++;
            if (act !== m) begin
                n_mis++;
                $display("FAIL outputs t=%0t got=%h want=%h", $time, act, m);
            end
            n_vec++;
            if (instr_count !== m_cnt[31:0] || b_instr_count !== 4'(m_cnt4)) begin
                n_mis++;
                $display("FAIL count t=%0t got=%0d/%0d want=%0d/%0d", $time,
                         instr_count, b_instr_count, m_cnt, m_cnt4);
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [8:0] ins, input logic st, input logic fl);
        valid_in = v; instr_in = ins; stall = st; flush = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] mk(input int op, input logic [3:0] lo);
        return {5'(op), lo};
    endfunction

    initial begin
        longint c0;
        reset = 1; valid_in = 0; instr_in = '0; stall = 0; flush = 0;
        cyc(0, 0, 0, 0);
        check_en = 1;
        cyc(0, 0, 0, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_wr", wr_reg, 31);
        chk("rst_cnt", instr_count, 0);
        chk("rst_halted", halted, 0);
        reset = 0;

        cyc(1, mk(0, 4'b0110), 0, 0);
        chk("add_valid", valid_out, 1); chk("add_rd0", rd0, 1); chk("add_rd1", rd1, 5);
        chk("add_wr", wr_reg, 2); chk("add_wren", wr_en, 1); chk("add_alu", alu_op, 0);
        chk("add_cnt", instr_count, 1); chk("model_add_wr", m.wr, 2);

        for (int op = 0; op < 26; op++) cyc(1, mk(op, 4'(op) ^ 4'h9), 0, 0);
        cyc(0, mk(0, 4'h5), 0, 0);
        chk("nv_bubble", valid_out, 0);

        cyc(1, mk(22, 4'b0011), 0, 0);
        chk("ld_memrd", mem_rd, 1); chk("ld_wr", wr_reg, 3);
        c0 = instr_count;
        for (int k = 0; k < 3; k++) begin
            cyc(1, mk(k, 4'(k + 1)), 1, 0);
            chk("stall_memrd", mem_rd, 1); chk("stall_wr", wr_reg, 3);
            chk("stall_cnt", instr_count, c0);
        end
        cyc(1, mk(17, 4'b1001), 0, 0);
        chk("post_stall_br", branch, 1); chk("post_stall_alu", alu_op, 6);
        chk("model_br_alu", m.alu, 6);

        c0 = instr_count;
        cyc(1, mk(16, 4'b0110), 1, 1);
        chk("sf_valid", valid_out, 0); chk("sf_branch", branch, 0);
        chk("sf_wr", wr_reg, 31); chk("sf_cnt", instr_count, c0);

        cyc(1, mk(28, 4'h0), 0, 0);
        chk("ill_set", illegal, 1); chk("ill_bubble", valid_out, 0);
        chk("ill_cnt", instr_count, c0);
        cyc(1, mk(1, 4'h3), 0, 0);
        cyc(1, mk(27, 4'h3), 0, 0);
        cyc(1, mk(31, 4'hF), 0, 0);
        cyc(1, mk(23, 4'h2), 0, 0);
        chk("ill_sticky", illegal, 1); chk("st_r2m", reg_to_mem, 2);

        c0 = instr_count;
        cyc(1, mk(26, 4'h0), 0, 0);
        chk("halt_halting", halting, 1); chk("halt_cnt", instr_count, c0 + 1);
        chk("halt_bubble", valid_out, 0);
        cyc(1, mk(0, 4'h1), 1, 0);
        chk("drain_stall_halting", halting, 1);
        cyc(1, mk(0, 4'h1), 0, 1);
        chk("drain_flush_halting", halting, 1);
        cyc(1, mk(0, 4'h1), 0, 0);
        chk("drain3_halting", halting, 1); chk("drain3_halted", halted, 0);
        cyc(1, mk(0, 4'h1), 0, 0);
        chk("halted", halted, 1); chk("halted_halting", halting, 0);
        cyc(1, mk(0, 4'h1), 0, 0);
        chk("halted_ign_valid", valid_out, 0); chk("halted_cnt", instr_count, c0 + 1);
        chk("model_halted", m.halted, 1);

        reset = 1;
        cyc(1, mk(0, 4'h1), 0, 0);
        chk("rst2_halted", halted, 0); chk("rst2_ill", illegal, 0);
        reset = 0;
        cyc(1, mk(0, 4'b0110), 0, 0);
        chk("run_again", valid_out, 1);

        for (int k = 0; k < 16; k++) cyc(1, mk(k % 2, 4'(k)), 0, 0);
        chk("sat4", b_instr_count, 15); chk("cnt32_17", instr_count, 17);
        cyc(1, mk(0, 4'h2), 0, 0);
        chk("sat4_hold", b_instr_count, 15); chk("model_sat4", m_cnt4, 15);

        cyc(0, 0, 0, 0);
        @(negedge clk);
        check_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/decode_stage_reg.md
Name: decode_stage_reg

Overview:
- Registered instruction-decode stage for the 9-bit accumulator ISA. It replaces the purely combinational control decoder in the pipelined CPU.
- It sits between the fetch register and the execute stage. It accepts one instruction per cycle with a valid flag and decodes it into control fields.
- It drives those fields from an ID/EX pipeline register that supports stall, flush and bubble insertion.
- It also adds a halt drain/halt state machine, a saturating dynamic-instruction counter and sticky illegal-opcode detection.

Parameters:
- INSTR_W, 9, instruction width; opcode is the top OPC_W bits.
- OPC_W, 5, opcode width.
- RADDR_W, 5, register-address width for rd0/rd1/wr_reg.
- CNT_W, 32, width of the dynamic-instruction counter.
- HALT_DRAIN, 3, cycles between accepting a halt and asserting halted (1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_in  in  INSTR_W  instruction from fetch.
- valid_in  in  1  instr_in is valid this cycle.
- stall  in  1  hazard stall; hold the pipeline register.
- flush  in  1  taken branch/jump; kill the instruction in decode.
- valid_out  out  1  pipeline register holds a live instruction.
- rd0  out  RADDR_W  read register 0.
- rd1  out  RADDR_W  read register 1.
- wr_reg  out  RADDR_W  write register (all-ones = none).
- wr_en  out  1  register write enable.
- alu_op  out  4  ALU operation.
- mem_rd  out  1  load.
- mem_wr  out  1  store.
- reg_to_mem  out  2  store source register.
- move  out  1  move-path select.
- imm  out  1  immediate select.
- quarter  out  2  quarter-select field.
- branch  out  1  conditional branch or jump.
- jump  out  1  unconditional jump.
- halting  out  1  halt accepted, draining.
- halted  out  1  sticky, processor halted.
- illegal  out  1  sticky, undefined opcode seen.
- instr_count  out  CNT_W  retired-decode count.

Behaviour:
- Reset:
  - valid_out, wr_en, mem_rd, mem_wr, move, imm, branch, jump, halting, halted, illegal are 0.
  - rd0, rd1, quarter, reg_to_mem, alu_op are 0; wr_reg is all-ones; instr_count is 0.
  - State machine goes to RUN. Reset overrides everything, including mid-drain and HALTED.
- Latency: an instruction accepted at edge N has its fields valid after edge N (one register stage).
- Per-edge priority: reset > flush > stall > accept.
  - flush=1: load a bubble (valid_out=0, every enable 0, wr_reg all-ones); counter unchanged. Flush wins over a simultaneous stall.
  - stall=1 (no flush): all outputs and instr_count hold; instr_in is ignored.
  - Otherwise, with valid_in=1 in RUN: decode and load; with valid_in=0: load a bubble.
- Decode uses opcode = instr_in[INSTR_W-1 -: OPC_W]. Encodings are per the ISA sheet:
  - 0–1 add/sub: rd0=i[3:2], rd1=5, wr=i[1:0], alu 0/1.
  - 2 mv: move, wr=i[1:0].
  - 3–14 moves/sets: special registers $adr=4, $math=5, $cnt=7; 6 and 14 set imm.
  - 15–19 branches: branch=1, wr_en=0, rd0=i[3:2], rd1=i[1:0], alu 7/8/6/5/4.
  - 20/21 evu/evl: alu 2/3.
  - 22 ld: mem_rd, wr=i[1:0], rd1=4.
  - 23 st: mem_wr, reg_to_mem=i[1:0], rd1=4.
  - 24 jump: branch=jump=1, alu 7.
  - 25 zeroReg: imm, wr=i[1:0].
  - 26 halt.
  - Opcodes ≥27: load a bubble and set illegal; no count.
  - Register addresses are zero-extended to RADDR_W.
- State machine:
  - RUN → DRAIN when a halt is accepted. The halt slot loads as a bubble, halting=1, and the drain counter loads HALT_DRAIN-1.
  - DRAIN: every slot is a bubble and inputs are ignored. The counter decrements each unstalled edge; when it reaches 0 → HALTED.
  - HALTED: halted=1, halting=0, every slot is a bubble. Only reset leaves this state.
  - flush during DRAIN does not cancel the halt.
- instr_count:
  - Increments by 1 on each edge that loads a decoded, non-bubble, legal instruction, including the halt itself.
  - Saturates at 2^CNT_W-1; it does not wrap.
- illegal is sticky until reset.

Test Plan:
- Reset, then add (opcode 0, i[3:0]=4'b0110) with valid_in=1 → next cycle: valid_out=1, rd0=1, rd1=5, wr_reg=2, wr_en=1, alu_op=0, instr_count=1.
- Accept ld, then hold stall=1 for 3 cycles while instr_in changes → mem_rd=1, wr_reg and instr_count unchanged throughout; after stall drops, the new instruction loads.
- stall=1 and flush=1 on the same edge with bne → bubble (valid_out=0, branch=0, wr_reg=31), instr_count unchanged.
- halt accepted, HALT_DRAIN=3 → halting=1 for 3 cycles; halted=1 on the 3rd edge after acceptance; instr_count +1; later valid add ignored; reset clears halted and state returns to RUN.
- Opcode 5'b11100 → bubble, illegal=1 stays set through subsequent legal instructions until reset.
- CNT_W=4: 17 legal instructions → instr_count=15, held at 15.
